// File: rtl/kf8253_bus_sequencer_if.sv
// Request/response handshake plus KF8253 CPU-bus pins between the host logic and the timer.
// The master modport is the sequencer; the slave modport is its environment.
interface kf8253_bus_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_address;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] bus_data_in;

  modport master (
    input  req_valid, req_write, req_address, req_data, bus_data_in,
    output req_ready, rsp_valid, rsp_data, busy,
           chip_select_n, read_enable_n, write_enable_n,
           address, bus_data_out, bus_data_oe
  );

  modport slave (
    output req_valid, req_write, req_address, req_data, bus_data_in,
    input  req_ready, rsp_valid, rsp_data, busy,
           chip_select_n, read_enable_n, write_enable_n,
           address, bus_data_out, bus_data_oe
  );
endinterface

// File: rtl/kf8253_bus_sequencer.sv
// Converts single-beat register requests into timed KF8253 CPU bus cycles
// (setup, strobe, hold, recovery); every bus pin is driven straight from a flop.
module kf8253_bus_sequencer #(
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  kf8253_bus_sequencer_if.master   bus
);

  localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > RECOVERY_CYCLES) ? HOLD_CYCLES : RECOVERY_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t S_LD = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t T_LD = cnt_t'(STROBE_CYCLES - 1);
  localparam cnt_t H_LD = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t R_LD = cnt_t'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t state, state_nx;
  cnt_t   cnt, cnt_nx;
  logic   wr, wr_nx;
  logic   accept;
  logic   on_bus;
  logic   ready_nx;
  logic   capture;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept   = 1'b1;
          state_nx = SETUP;
          cnt_nx   = S_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = T_LD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = H_LD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (RECOVERY_CYCLES > 0) begin
          state_nx = RECOVER;
          cnt_nx   = R_LD;
        end else if (bus.req_valid && bus.req_ready) begin
          // No recovery: the last hold cycle doubles as the accept slot, so CS stays low.
          accept   = 1'b1;
          state_nx = SETUP;
          cnt_nx   = S_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    wr_nx    = accept ? bus.req_write : wr;
    on_bus   = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    ready_nx = (state_nx == IDLE) ||
               ((RECOVERY_CYCLES == 0) && (state_nx == HOLD) && (cnt_nx == '0));
    capture  = (state == STROBE) && (state_nx == HOLD) && !wr;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= '0;
      wr                 <= 1'b0;
      bus.req_ready      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.chip_select_n  <= 1'b1;
      bus.read_enable_n  <= 1'b1;
      bus.write_enable_n <= 1'b1;
      bus.bus_data_oe    <= 1'b0;
      bus.address        <= 2'd0;
      bus.bus_data_out   <= 8'd0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_data       <= 8'd0;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      wr                 <= wr_nx;
      bus.req_ready      <= ready_nx;
      bus.busy           <= (state_nx != IDLE);
      bus.chip_select_n  <= !on_bus;
      bus.bus_data_oe    <= on_bus && wr_nx;
      bus.write_enable_n <= !((state_nx == STROBE) && wr_nx);
      bus.read_enable_n  <= !((state_nx == STROBE) && !wr_nx);
      bus.rsp_valid      <= capture;
      if (accept) begin
        bus.address      <= bus.req_address;
        bus.bus_data_out <= bus.req_data;
      end
      if (capture) begin
        bus.rsp_data <= bus.bus_data_in;
      end
    end
  end

endmodule

// File: tb/tb_kf8253_bus_sequencer.sv
// Bench for kf8253_bus_sequencer: default timing and a 3,4,2,0 instance share one
// stimulus stream; each is compared per cycle against a cycle-offset reference model.
module tb_kf8253_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld;
  logic       wr;
  logic [1:0] ad;
  logic [7:0] dt;
  logic [7:0] din;
  bit         rand_din;

  kf8253_bus_sequencer_if bi0();
  kf8253_bus_sequencer_if bi1();

  assign bi0.req_valid   = vld;
  assign bi0.req_write   = wr;
  assign bi0.req_address = ad;
  assign bi0.req_data    = dt;
  assign bi0.bus_data_in = din;
  assign bi1.req_valid   = vld;
  assign bi1.req_write   = wr;
  assign bi1.req_address = ad;
  assign bi1.req_data    = dt;
  assign bi1.bus_data_in = din;

  kf8253_bus_sequencer u_dut0 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bi0)
  );

  kf8253_bus_sequencer #(
    .SETUP_CYCLES    (3),
    .STROBE_CYCLES   (4),
    .HOLD_CYCLES     (2),
    .RECOVERY_CYCLES (0)
  ) u_dut1 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bi1)
  );

  int ps[2] = '{1, 3};
  int pt[2] = '{2, 4};
  int ph[2] = '{1, 2};
  int pr[2] = '{1, 0};

  // Reference model: one record per instance; every bus pin follows from the
  // cycle offset since the accepting edge.
  bit         m_act[2];
  bit         m_up[2];
  int         m_e0[2];
  bit         m_wr[2];
  logic [1:0] m_ad[2];
  logic [7:0] m_dt[2];
  logic [7:0] m_rsp[2];
  int         m_nacc[2];
  int         edge_n;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    int o, l;
    if (!m_up[i]) return 1'b0;
    if (!m_act[i]) return 1'b1;
    o = edge_n - m_e0[i];
    l = ps[i] + pt[i] + ph[i];
    if (pr[i] > 0) return (o >= l + pr[i] + 1);
    return (o >= l);
  endfunction

  task automatic model_edge(input int i);
    int o;
    bit rdy;
    if (!rst_n) begin
      m_act[i] = 1'b0;
      m_up[i]  = 1'b0;
      m_ad[i]  = 2'd0;
      m_rsp[i] = 8'd0;
    end else begin
      o   = edge_n - m_e0[i];
      rdy = m_ready(i);
      if (m_act[i] && !m_wr[i] && o == ps[i] + pt[i]) m_rsp[i] = din;
      if (rdy && vld) begin
        m_act[i] = 1'b1;
        m_e0[i]  = edge_n;
        m_wr[i]  = wr;
        m_ad[i]  = ad;
        m_dt[i]  = dt;
        m_nacc[i]++;
      end
      m_up[i] = 1'b1;
    end
  endtask

  task automatic check_inst(input int i, input logic cs, input logic re, input logic we,
                            input logic oe, input logic rv, input logic by, input logic rdy,
                            input logic [1:0] adr, input logic [7:0] dout, input logic [7:0] rd);
    int    o, l;
    bit    on, stb;
    string p;
    p   = $sformatf("u%0d@%0d", i, edge_n);
    l   = ps[i] + pt[i] + ph[i];
    o   = edge_n - m_e0[i];
    on  = m_act[i] && o >= 1 && o <= l;
    stb = m_act[i] && o >= ps[i] + 1 && o <= ps[i] + pt[i];
    chk({p, " cs_n"}, 32'(cs), 32'(!on));
    chk({p, " rd_n"}, 32'(re), 32'(!(stb && !m_wr[i])));
    chk({p, " wr_n"}, 32'(we), 32'(!(stb && m_wr[i])));
    chk({p, " oe"}, 32'(oe), 32'(on && m_wr[i]));
    chk({p, " rsp_valid"}, 32'(rv), 32'(m_act[i] && !m_wr[i] && o == ps[i] + pt[i] + 1));
    chk({p, " busy"}, 32'(by), 32'(m_act[i] && o >= 1 && o <= l + pr[i]));
    chk({p, " ready"}, 32'(rdy), 32'(m_ready(i)));
    chk({p, " addr"}, 32'(adr), 32'(m_ad[i]));
    chk({p, " rsp_data"}, 32'(rd), 32'(m_rsp[i]));
    if (on && m_wr[i]) chk({p, " dout"}, 32'(dout), 32'(m_dt[i]));
    chk({p, " both_strobes_low"}, 32'(!re && !we), 32'd0);
    chk({p, " strobe_without_cs"}, 32'((!re || !we) && cs), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    edge_n++;
    @(negedge clk);
    check_inst(0, bi0.chip_select_n, bi0.read_enable_n, bi0.write_enable_n, bi0.bus_data_oe,
               bi0.rsp_valid, bi0.busy, bi0.req_ready, bi0.address, bi0.bus_data_out, bi0.rsp_data);
    check_inst(1, bi1.chip_select_n, bi1.read_enable_n, bi1.write_enable_n, bi1.bus_data_oe,
               bi1.rsp_valid, bi1.busy, bi1.req_ready, bi1.address, bi1.bus_data_out, bi1.rsp_data);
    if (rand_din) din = 8'($urandom);
  endtask

  // Holds the request until instance 0 takes it; leaves req_valid asserted.
  task automatic issue(input bit w, input logic [1:0] a, input logic [7:0] d);
    int n0;
    int k;
    n0  = m_nacc[0];
    k   = 0;
    vld = 1'b1;
    wr  = w;
    ad  = a;
    dt  = d;
    while (m_nacc[0] == n0 && k < 40) begin
      tick();
      k++;
    end
  endtask

  task automatic abort_mid_strobe(input bit w);
    issue(w, 2'd1, 8'h5A);
    vld = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort u0 cs_n", 32'(bi0.chip_select_n), 32'd1);
    chk("abort u0 rd_n", 32'(bi0.read_enable_n), 32'd1);
    chk("abort u0 wr_n", 32'(bi0.write_enable_n), 32'd1);
    chk("abort u0 oe", 32'(bi0.bus_data_oe), 32'd0);
    chk("abort u0 rsp_valid", 32'(bi0.rsp_valid), 32'd0);
    chk("abort u1 cs_n", 32'(bi1.chip_select_n), 32'd1);
    chk("abort u1 rd_n", 32'(bi1.read_enable_n), 32'd1);
    chk("abort u1 wr_n", 32'(bi1.write_enable_n), 32'd1);
    chk("abort u1 oe", 32'(bi1.bus_data_oe), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    edge_n   = 0;
    rand_din = 1'b0;
    rst_n    = 1'b0;
    vld      = 1'b0;
    wr       = 1'b0;
    ad       = 2'd0;
    dt       = 8'd0;
    din      = 8'd0;
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_up[i]   = 1'b0;
      m_e0[i]   = 0;
      m_wr[i]   = 1'b0;
      m_ad[i]   = 2'd0;
      m_dt[i]   = 8'd0;
      m_rsp[i]  = 8'd0;
      m_nacc[i] = 0;
    end

    repeat (3) begin
      tick();
      chk("rst u0 dout", 32'(bi0.bus_data_out), 32'd0);
      chk("rst u1 dout", 32'(bi1.bus_data_out), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write, then a read with a fixed byte on the bus.
    issue(1'b1, 2'd3, 8'h34);
    vld = 1'b0;
    repeat (12) tick();
    din = 8'hA5;
    issue(1'b0, 2'd0, 8'hFF);
    vld = 1'b0;
    repeat (14) tick();

    // Back-to-back writes with req_valid held.
    issue(1'b1, 2'd3, 8'h34);
    issue(1'b1, 2'd0, 8'h10);
    issue(1'b1, 2'd0, 8'h00);
    vld = 1'b0;
    repeat (14) tick();

    // Random traffic, including request changes while busy.
    rand_din = 1'b1;
    repeat (600) begin
      vld = ($urandom_range(0, 2) != 0);
      wr  = 1'($urandom);
      ad  = 2'($urandom);
      dt  = 8'($urandom);
      tick();
    end
    vld = 1'b0;
    repeat (14) tick();

    abort_mid_strobe(1'b0);
    abort_mid_strobe(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
